tx_block_buffer: RTL and testbench
==================================

# tx_block_buffer

Word-to-block buffer between the output multiplexer and the host link. It accepts 32-bit words from the output stage through the `FIFO_tx_din`/`FIFO_tx_enable`/`FIFO_tx_block_full` interface and stores them in a circular buffer. It releases them to the host transmitter as fixed-length blocks of `BLOCK_WORDS` beats on a valid/ready stream. When the frame ends, a partial trailing block is padded out to full length so the host always receives whole blocks.

## Interface
- `DEPTH`, 512: buffer depth in words; power of two, at least 2×`BLOCK_WORDS`.
- `BLOCK_WORDS`, 64: beats per host block; power of two.
- `PAD_WORD`, 32'h0000_0000: word used to fill a partial final block.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `FIFO_tx_din`  in  32  word from the output stage.
- `FIFO_tx_enable`  in  1  write strobe; one word per cycle while high.
- `FIFO_tx_block_full`  out  1  high when free entries < `BLOCK_WORDS`.
- `flush`  in  1  frame-complete pulse; requests emission of the partial block.
- `host_data`  out  32  stream data.
- `host_valid`  out  1  `host_data` is valid.
- `host_ready`  in  1  host accepts the beat.
- `host_last`  out  1  marks the final beat of a block.
- `level`  out  log2(DEPTH)+1  words currently stored.
- `overflow`  out  1  sticky; a write arrived while the buffer was full.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr` of log2(DEPTH) bits each, which wrap naturally.
- `count` has log2(DEPTH)+1 bits; `level` = `count`.
- Write path:
  - `FIFO_tx_enable` with `count` < `DEPTH`: store the word and increment `wr_ptr`.
  - `FIFO_tx_enable` with `count` == `DEPTH`: drop the word and set `overflow`. `overflow` clears only on reset.
- `count` update per cycle:
  - +1 for an accepted write.
  - −1 for a beat popped from the buffer.
  - Unchanged when both occur in the same cycle. PAD beats do not pop.
- `flush` sets `flush_pending`. A pulse while it is already set has no further effect.
- Read FSM states are IDLE, SEND, and PAD.
  - **IDLE, `count` ≥ `BLOCK_WORDS`:** go to SEND. Set `real_left` = `BLOCK_WORDS` and `beat` = 0.
  - **IDLE, otherwise, `flush_pending` and `count` > 0:** go to SEND with `real_left` = `count`, sampled this cycle. This is a partial block.
  - **IDLE, otherwise, `flush_pending` and `count` == 0:** clear `flush_pending` and stay in IDLE.
  - **SEND:** present `mem[rd_ptr]`. On a handshake, increment `rd_ptr` and `beat` and decrement `real_left`. When `real_left` reaches 0 with `beat` < `BLOCK_WORDS`, go to PAD.
  - **PAD:** present `PAD_WORD`. Each handshake increments `beat`.
  - **Block end (SEND or PAD):** when the beat at `beat` == `BLOCK_WORDS`−1 is handshaked, go to IDLE. If the block was partial, clear `flush_pending`.
- `host_last` = (`beat` == `BLOCK_WORDS`−1) while `host_valid` is high.
- Words written during a partial block are not included in it; they wait for the next block.

## Timing
- Reset values:
  - Outputs `host_valid`, `host_last`, `overflow`, `FIFO_tx_block_full` are 0, `host_data` is 0, and `level` is 0.
  - Internal state is IDLE, pointers are 0, and `flush_pending` is 0.
- Reset is asynchronous mid-block: the block is abandoned, stored data is discarded, and no partial block resumes.
- A write is visible in `level` on the next cycle.
- `FIFO_tx_block_full` is registered from the updated `count`, one cycle after the write.
- `host_valid` is registered:
  - It rises one cycle after the IDLE→SEND decision.
  - It stays high through the block, with no bubbles while `host_ready` is held high.
  - It drops for exactly one cycle between consecutive blocks, in IDLE.
- `host_data`, `host_valid`, and `host_last` hold stable while `host_valid` is high and `host_ready` is low.
- Block throughput is one beat per cycle, giving `BLOCK_WORDS`+1 cycles per block with `host_ready` held high.
- A simultaneous write and pop leave `count` unchanged. A write at full with a pop in the same cycle is accepted.

## Test plan
- **Full block:** write 64 words 1..64 back-to-back with `host_ready`=1. Expect 64 beats with data 1..64, `host_last` only on 64, and `level` returning to 0.
- **Partial flush:** write 10 words 0xA0..0xA9, then pulse `flush`. Expect one block of 64 beats: 0xA0..0xA9 followed by 54 × 0x00000000, with `host_last` on beat 64 and `flush_pending` cleared.
- **Backpressure:** stream 128 words while toggling `host_ready` randomly. Expect data, order, and `host_last` positions unchanged, and outputs stable during stall cycles.
- **Full/overflow:** hold `host_ready`=0 and write 512 words.
  - `FIFO_tx_block_full` rises the cycle after the 449th accepted write.
  - A 513th write is dropped and `overflow`=1.
  - When `host_ready` is released, exactly 512 words are emitted in order.
- **Wrap-around with simultaneous read/write:** after 600 total words with concurrent reads and writes, expect data in order across the pointer wrap, and `level` matching the scoreboard every cycle.
- **Reset mid-block:** assert `rst_n`=0 at beat 20 of a block. Expect all outputs at reset values immediately, `level`=0, and no further beats until new writes arrive.

Source files
------------

// File: rtl/tx_block_buffer.sv
// Circular word buffer that releases fixed-length blocks to the host stream,
// padding a flushed partial block out to BLOCK_WORDS beats.
module tx_block_buffer #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned BLOCK_WORDS = 64,
  parameter logic [31:0] PAD_WORD    = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              FIFO_tx_din,
  input  logic                     FIFO_tx_enable,
  output logic                     FIFO_tx_block_full,
  input  logic                     flush,
  output logic [31:0]              host_data,
  output logic                     host_valid,
  input  logic                     host_ready,
  output logic                     host_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  localparam logic [CW-1:0] BlockCnt = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0] FullThr  = CW'(DEPTH - BLOCK_WORDS);
  localparam logic [BW-1:0] LastBeat = BW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StSend, StPad} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   rd_next;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   real_left_q, real_left_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            partial_q, partial_d;
  logic            flush_pend_q, flush_pend_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic [31:0]     data_q, data_d;
  logic            full_q, full_d;
  logic            overflow_q, overflow_d;
  logic            hs;
  logic            pop;
  logic            wr_accept;

  logic [31:0] mem [DEPTH];

  assign rd_next = rd_ptr_q + AW'(1);
  assign hs      = valid_q & host_ready;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    real_left_d  = real_left_q;
    beat_d       = beat_q;
    partial_d    = partial_q;
    flush_pend_d = flush_pend_q | flush;
    valid_d      = valid_q;
    last_d       = last_q;
    data_d       = data_q;
    pop          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (count_q >= BlockCnt) begin
          state_d     = StSend;
          real_left_d = BlockCnt;
          beat_d      = '0;
          partial_d   = 1'b0;
          valid_d     = 1'b1;
          last_d      = (BLOCK_WORDS == 1);
          data_d      = mem[rd_ptr_q];
        end else if (flush_pend_q && count_q != '0) begin
          // Only the words present now belong to the partial block.
          state_d     = StSend;
          real_left_d = count_q;
          beat_d      = '0;
          partial_d   = 1'b1;
          valid_d     = 1'b1;
          last_d      = (BLOCK_WORDS == 1);
          data_d      = mem[rd_ptr_q];
        end else if (flush_pend_q) begin
          flush_pend_d = flush;
        end
      end
      StSend, StPad: begin
        if (hs) begin
          beat_d = beat_q + BW'(1);
          if (state_q == StSend) begin
            pop         = 1'b1;
            rd_ptr_d    = rd_next;
            real_left_d = real_left_q - CW'(1);
          end
          if (beat_q == LastBeat) begin
            state_d = StIdle;
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (partial_q) flush_pend_d = flush;
          end else begin
            last_d = (beat_d == LastBeat);
            if (state_q == StPad || real_left_q == CW'(1)) begin
              state_d = StPad;
              data_d  = PAD_WORD;
            end else begin
              data_d = mem[rd_next];
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A pop in the same cycle frees the slot, so a write at full is still taken.
    wr_accept  = FIFO_tx_enable & ((count_q != DepthCnt) | pop);
    overflow_d = overflow_q | (FIFO_tx_enable & ~wr_accept);
    if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);

    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d > FullThr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      real_left_q  <= '0;
      beat_q       <= '0;
      partial_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      data_q       <= '0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      real_left_q  <= real_left_d;
      beat_q       <= beat_d;
      partial_q    <= partial_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      data_q       <= data_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= FIFO_tx_din;
  end

  assign host_data          = data_q;
  assign host_valid         = valid_q;
  assign host_last          = last_q;
  assign level              = count_q;
  assign overflow           = overflow_q;
  assign FIFO_tx_block_full = full_q;

endmodule

// File: tb/tb_tx_block_buffer.sv
// Scoreboard bench for tx_block_buffer: stimulus queues expected beats,
// a negedge monitor pops and compares every handshaked beat and the level.
module tb_tx_block_buffer;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned BW    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] FIFO_tx_din = '0;
  logic        FIFO_tx_enable = 1'b0;
  logic        FIFO_tx_block_full;
  logic        flush = 1'b0;
  logic [31:0] host_data;
  logic        host_valid;
  logic        host_ready = 1'b0;
  logic        host_last;
  logic [9:0]  level;
  logic        overflow;

  tx_block_buffer #(.DEPTH(DEPTH), .BLOCK_WORDS(BW), .PAD_WORD(32'h0)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .FIFO_tx_din       (FIFO_tx_din),
    .FIFO_tx_enable    (FIFO_tx_enable),
    .FIFO_tx_block_full(FIFO_tx_block_full),
    .flush             (flush),
    .host_data         (host_data),
    .host_valid        (host_valid),
    .host_ready        (host_ready),
    .host_last         (host_last),
    .level             (level),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        pad;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt = 0;
  int   rd_real = 0;
  int   beat_idx = 0;
  int   seen_beats = 0;
  bit   mon_on = 1'b0;
  int   ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0: ready low, 1: ready high, otherwise random
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       host_ready = 1'b0;
      1:       host_ready = 1'b1;
      default: host_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin : monitor
    logic [31:0] pdata;
    logic        plast;
    bit          stall;
    exp_t        e;
    stall = 1'b0;
    pdata = '0;
    plast = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_on) begin
        stall = 1'b0;
        continue;
      end
      chk("level", 32'(level), 32'(wr_cnt - rd_real));
      if (stall) begin
        chk("stall_data", host_data, pdata);
        chk("stall_ctl", {30'b0, host_valid, host_last}, {30'b0, 1'b1, plast});
      end
      if (host_valid && host_ready) begin
        seen_beats++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got %0h expected none", host_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", host_data, e.data);
          chk("beat_last", 32'(host_last), 32'(beat_idx == BW - 1));
          if (!e.pad) rd_real++;
        end
        beat_idx = (beat_idx + 1) % BW;
      end
      stall = host_valid && !host_ready;
      pdata = host_data;
      plast = host_last;
    end
  end

  task automatic wr(input logic [31:0] d, input bit acc);
    exp_t e;
    e.data = d;
    e.pad  = 1'b0;
    FIFO_tx_din    = d;
    FIFO_tx_enable = 1'b1;
    if (acc) exp_q.push_back(e);
    @(posedge clk);
    if (acc) wr_cnt++;
    #1 FIFO_tx_enable = 1'b0;
  endtask

  task automatic do_flush(input int pads);
    exp_t e;
    e.data = 32'h0;
    e.pad  = 1'b1;
    for (int i = 0; i < pads; i++) exp_q.push_back(e);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || host_valid) && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    chk({name, "_idle"}, 32'(host_valid), 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 32'(host_valid), 32'd0);
    chk({tag, "_last"}, 32'(host_last), 32'd0);
    chk({tag, "_data"}, host_data, 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_full"}, 32'(FIFO_tx_block_full), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;
    mon_on = 1'b1;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;

    // Full block
    for (int i = 1; i <= 64; i++) wr(32'(i), 1'b1);
    drain("full_block_drain");
    chk("full_block_level", 32'(level), 32'd0);

    // Partial flush
    for (int i = 0; i < 10; i++) wr(32'hA0 + 32'(i), 1'b1);
    do_flush(54);
    drain("partial_drain");
    repeat (3) @(posedge clk);
    #1;
    chk("flush_pending_cleared", 32'(dut.flush_pend_q), 32'd0);

    // Backpressure
    ready_mode = 2;
    for (int i = 0; i < 128; i++) wr(32'h100 + 32'(i), 1'b1);
    drain("backpressure_drain");
    ready_mode = 1;

    // Full / overflow
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i <= 512; i++) begin
      wr(32'h4000 + 32'(i), 1'b1);
      if (i == 448) chk("full_at_448", 32'(FIFO_tx_block_full), 32'd0);
      if (i == 449) chk("full_at_449", 32'(FIFO_tx_block_full), 32'd1);
    end
    chk("no_overflow_at_512", 32'(overflow), 32'd0);
    wr(32'hDEAD_BEEF, 1'b0);
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("level_at_full", 32'(level), 32'd512);
    ready_mode = 1;
    drain("overflow_drain");

    // Wrap-around with concurrent reads and writes
    for (int i = 0; i < 600; i++) wr(32'h8000 + 32'(i), 1'b1);
    do_flush(40);
    drain("wrap_drain");

    // Reset mid-block
    for (int i = 0; i < 64; i++) wr(32'h2000 + 32'(i), 1'b1);
    n = 0;
    while (seen_beats < 64 + 10 + 54 + 128 + 512 + 640 + 20 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_beat_20", 32'(n < 500), 32'd1);
    mon_on = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    exp_q.delete();
    wr_cnt = 0;
    rd_real = 0;
    beat_idx = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_on = 1'b1;
    n = seen_beats;
    repeat (100) @(posedge clk);
    #1;
    chk("no_beats_after_reset", 32'(seen_beats - n), 32'd0);
    chk("level_after_reset", 32'(level), 32'd0);
    for (int i = 0; i < 64; i++) wr(32'h3000 + 32'(i), 1'b1);
    drain("post_reset_drain");
    chk("post_reset_level", 32'(level), 32'd0);

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
